// File: rtl/hamming_rx_frame_ctrl.sv
// Serial Hamming(7,4) receive framer: collects 7-bit codewords, corrects single-bit
// errors, queues decoded nibbles in a small FIFO and tracks link error statistics.
module hamming_rx_frame_ctrl #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sof,
  output logic [3:0]       out_data,
  output logic             out_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  output logic             frame_err,
  input  logic             clr_count,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DECODE, STALL} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [6:0]         shreg_q, shreg_d;
  logic [4:0]         mem_q [DEPTH];
  logic [4:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     fill_q, fill_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic               pop;
  logic               push;
  logic               pending;
  logic [2:0]         syndrome;
  logic [6:0]         flip;
  logic [6:0]         fixed;
  logic [4:0]         entry;

  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign pending = (state_q == DECODE) || (state_q == STALL);
  assign push    = pending && ((fill_q < DEPTH_C) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = COLLECT;
      COLLECT: if (accept && !sof && (cnt_q == 3'd6)) state_d = DECODE;
      DECODE,
      STALL:   state_d = push ? IDLE : STALL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == COLLECT);
    busy     = (state_q != IDLE);
  end

  // Syndrome value names the flipped position by its parity-check column.
  always_comb begin
    syndrome = {shreg_q[2] ^ shreg_q[4] ^ shreg_q[5] ^ shreg_q[6],
                shreg_q[1] ^ shreg_q[3] ^ shreg_q[4] ^ shreg_q[5],
                shreg_q[0] ^ shreg_q[3] ^ shreg_q[5] ^ shreg_q[6]};
    flip = 7'b0000000;
    case (syndrome)
      3'b001:  flip = 7'b0000001;
      3'b010:  flip = 7'b0000010;
      3'b100:  flip = 7'b0000100;
      3'b011:  flip = 7'b0001000;
      3'b110:  flip = 7'b0010000;
      3'b111:  flip = 7'b0100000;
      3'b101:  flip = 7'b1000000;
      default: flip = 7'b0000000;
    endcase
    fixed = shreg_q ^ flip;
    entry = {(syndrome != 3'b000), fixed[6:3]};
  end

  // A sof mid-word restarts the count; older bits simply shift out of the register.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      shreg_d = {shreg_q[5:0], in_bit};
      if ((state_q == IDLE) || sof) begin
        cnt_d = 3'd1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      if (sof && (state_q == COLLECT)) begin
        frame_err_d = 1'b1;
      end
    end
    if (push) begin
      cnt_d = 3'd0;
      if (entry[4] && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + 1'b1;
      end
    end
    if (clr_count) begin
      err_d       = '0;
      frame_err_d = 1'b0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      err_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      err_q       <= err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid     = (fill_q != '0);
  assign out_data      = mem_q[rd_ptr_q][3:0];
  assign out_corrected = mem_q[rd_ptr_q][4];
  assign err_count     = err_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_hamming_rx_frame_ctrl.sv
// Directed bench for hamming_rx_frame_ctrl: a vector table of codewords plus
// hand-written sequences for resync, backpressure, counter clear/saturation and reset.
module tb_hamming_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_bit, in_valid, sof, out_ready, clr_count;
  logic       in_ready, out_corrected, out_valid, frame_err, busy;
  logic [3:0] out_data;
  logic [7:0] err_count;

  logic       sat_in_ready, sat_out_corrected, sat_out_valid, sat_frame_err, sat_busy;
  logic [3:0] sat_out_data;
  logic [1:0] sat_err_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [6:0] word;
    logic [3:0] data;
    logic       corr;
  } vec_t;

  vec_t vecs [14];
  logic [3:0] drain_exp [3];

  always #5 clk = ~clk;

  hamming_rx_frame_ctrl #(.CNT_W(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .sof(sof), .out_data(out_data),
    .out_corrected(out_corrected), .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count), .frame_err(frame_err), .clr_count(clr_count),
    .busy(busy)
  );

  hamming_rx_frame_ctrl #(.CNT_W(2), .DEPTH(2)) dut_sat (
    .clk(clk), .reset(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(sat_in_ready), .sof(sof), .out_data(sat_out_data),
    .out_corrected(sat_out_corrected), .out_valid(sat_out_valid),
    .out_ready(out_ready), .err_count(sat_err_count), .frame_err(sat_frame_err),
    .clr_count(clr_count), .busy(sat_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] word, input logic with_sof);
    int budget;
    for (int i = 6; i >= 0; i--) begin
      in_bit   = word[i];
      sof      = with_sof && (i == 6);
      in_valid = 1'b1;
      budget   = 0;
      while (!in_ready && budget < 20) begin
        step();
        budget++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
      end
      step();
    end
    in_valid = 1'b0;
    sof      = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic int satModel(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  initial begin
    int got;

    reset_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; sof = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;

    vecs[0] = '{7'b1011000, 4'b1011, 1'b0};
    for (int k = 0; k < 7; k++) begin
      vecs[1 + k] = '{7'b1011000 ^ (7'b0000001 << k), 4'b1011, 1'b1};
    end
    vecs[8]  = '{7'b0110001, 4'b0110, 1'b0};
    vecs[9]  = '{7'b1110001, 4'b0110, 1'b1};
    vecs[10] = '{7'b1111111, 4'b1111, 1'b0};
    vecs[11] = '{7'b1111110, 4'b1111, 1'b1};
    vecs[12] = '{7'b0000000, 4'b0000, 1'b0};
    vecs[13] = '{7'b0000100, 4'b0000, 1'b1};
    drain_exp[0] = 4'b1011;
    drain_exp[1] = 4'b0110;
    drain_exp[2] = 4'b1111;

    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_corrected", out_corrected, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_busy", busy, 0);
    #9 reset_n = 1'b1;
    step();
    checkOutput("in_ready_after_reset", in_ready, 1);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].word, 1'b0);
      checkOutput("in_ready_decode", in_ready, 0);
      checkOutput("sat_in_ready_decode", sat_in_ready, 0);
      checkOutput("busy_decode", busy, 1);
      step();
      if (vecs[v].corr) exp_cnt++;
      checkOutput("in_ready_back", in_ready, 1);
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", out_data, vecs[v].data);
      checkOutput("out_corrected", out_corrected, vecs[v].corr);
      checkOutput("sat_out_data", sat_out_data, vecs[v].data);
      checkOutput("sat_out_corrected", sat_out_corrected, vecs[v].corr);
      checkOutput("err_count", err_count, exp_cnt);
      checkOutput("sat_err_count", sat_err_count, satModel(exp_cnt));
      popOne();
      checkOutput("out_valid_popped", out_valid, 0);
      checkOutput("sat_out_valid_popped", sat_out_valid, 0);
    end
    checkOutput("err_count_table_total", err_count, 10);

    in_valid = 1'b1;
    in_bit = 1'b1; step();
    in_bit = 1'b1; step();
    in_bit = 1'b0; step();
    in_valid = 1'b0;
    checkOutput("resync_busy_partial", busy, 1);
    checkOutput("resync_sat_busy_partial", sat_busy, 1);
    checkOutput("resync_frame_err_before", frame_err, 0);
    applyStimulus(7'b1011000, 1'b1);
    checkOutput("resync_frame_err", frame_err, 1);
    checkOutput("resync_sat_frame_err", sat_frame_err, 1);
    step();
    checkOutput("resync_out_valid", out_valid, 1);
    checkOutput("resync_out_data", out_data, 4'b1011);
    checkOutput("resync_out_corrected", out_corrected, 0);
    popOne();
    checkOutput("resync_single_entry", out_valid, 0);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    exp_cnt = 0;
    checkOutput("clr_frame_err", frame_err, 0);
    checkOutput("clr_err_count", err_count, 0);
    checkOutput("clr_sat_err_count", sat_err_count, 0);

    applyStimulus(drain_exp[0] == 4'b1011 ? 7'b1011000 : 7'b0000000, 1'b0);
    step();
    applyStimulus(7'b0110001, 1'b0);
    step();
    applyStimulus(7'b1111111, 1'b0);
    step();
    step();
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_busy", busy, 1);
    checkOutput("stall_out_valid", out_valid, 1);
    checkOutput("stall_head", out_data, 4'b1011);
    out_ready = 1'b1;
    got = 0;
    while (out_valid && got < 10) begin
      if (got < 3) checkOutput("drain_data", out_data, drain_exp[got]);
      got++;
      step();
    end
    out_ready = 1'b0;
    checkOutput("drain_count", got, 3);

    applyStimulus(7'b1110001, 1'b0);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    checkOutput("clr_push_corrected", out_corrected, 1);
    checkOutput("clr_push_err_count", err_count, 0);
    checkOutput("clr_push_sat_err_count", sat_err_count, 0);
    popOne();

    for (int n = 0; n < 5; n++) begin
      applyStimulus(7'b0000100, 1'b0);
      step();
      exp_cnt++;
      popOne();
    end
    checkOutput("sat_hold", sat_err_count, 3);
    checkOutput("nosat_count", err_count, exp_cnt);

    in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_bit = n[0];
      step();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_err_count", err_count, 0);
    checkOutput("async_sat_err_count", sat_err_count, 0);
    checkOutput("async_frame_err", frame_err, 0);
    checkOutput("async_out_data", out_data, 0);
    #3 reset_n = 1'b1;
    step();
    checkOutput("async_in_ready", in_ready, 1);
    applyStimulus(7'b0110001, 1'b0);
    step();
    checkOutput("post_reset_data", out_data, 4'b0110);
    checkOutput("post_reset_valid", out_valid, 1);
    popOne();

    applyStimulus(7'b1011000, 1'b0);
    step();
    applyStimulus(7'b0110001, 1'b0);
    step();
    applyStimulus(7'b1111111, 1'b0);
    step();
    checkOutput("stall2_in_ready", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("stall_reset_out_valid", out_valid, 0);
    checkOutput("stall_reset_busy", busy, 0);
    #3 reset_n = 1'b1;
    step();
    applyStimulus(7'b1111110, 1'b0);
    step();
    checkOutput("after_stall_reset_data", out_data, 4'b1111);
    checkOutput("after_stall_reset_corr", out_corrected, 1);
    checkOutput("after_stall_reset_count", err_count, 1);
    popOne();
    checkOutput("after_stall_reset_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
